// File: rtl/roic_channel_scheduler.sv
// ============================================================================
// roic_channel_scheduler
//
// Readout scheduler for the ROIC channel array, running in the data_read_clk
// domain. A scan starts on `start` and walks the enabled channels in
// ascending index order. For each channel the scheduler raises
// data_read_req, waits for a valid reordered A/B pair, and forwards the pair
// as one tagged word on a valid/ready stream. A per-channel timeout skips a
// dead ROIC, so one stalled channel cannot hang the scan.
//
// Ports
//   data_read_clk      clock
//   deser_reset        synchronous, active-high reset
//   start              begin a scan (accepted only when idle)
//   ch_enable          channel mask, sampled when start is accepted
//   valid_read_enable  per-channel read enable from the channel array
//   reordered_valid    per-channel data-valid flag
//   reordered_data_a/b flattened per-channel data, channel i at
//                      [i*DATA_WIDTH +: DATA_WIDTH]
//   data_read_req      registered, one-hot or zero read request
//   out_data           {B, A} of the captured channel
//   out_ch             channel index of out_data
//   out_valid/ready    output stream handshake
//   out_last           word belongs to the final pending channel of the scan
//   busy               scan in progress (SELECT, WAIT, OUT)
//   done               one-cycle pulse at scan end
//   timeout_err        sticky per-channel timeout flags, cleared on start
// ============================================================================
module roic_channel_scheduler #(
    parameter  int N_CH        = 12,
    parameter  int DATA_WIDTH  = 24,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       data_read_clk,
    input  logic                       deser_reset,
    input  logic                       start,
    input  logic [N_CH-1:0]            ch_enable,
    input  logic [N_CH-1:0]            valid_read_enable,
    input  logic [N_CH-1:0]            reordered_valid,
    input  logic [N_CH*DATA_WIDTH-1:0] reordered_data_a,
    input  logic [N_CH*DATA_WIDTH-1:0] reordered_data_b,
    output logic [N_CH-1:0]            data_read_req,
    output logic [2*DATA_WIDTH-1:0]    out_data,
    output logic [CH_W-1:0]            out_ch,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic [N_CH-1:0]            timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] TIMER_MAX  = 16'hFFFF;

    state_t                    state_q,    state_d;
    logic [N_CH-1:0]           pending_q,  pending_d;
    logic [N_CH-1:0]           cur_mask_q, cur_mask_d;   // one-hot of the channel being served
    logic [CH_W-1:0]           idx_q,      idx_d;
    logic [15:0]               timer_q,    timer_d;
    logic [N_CH-1:0]           req_q,      req_d;
    logic [2*DATA_WIDTH-1:0]   data_q,     data_d;
    logic [CH_W-1:0]           ch_q,       ch_d;
    logic                      valid_q,    valid_d;
    logic                      last_q,     last_d;
    logic [N_CH-1:0]           tmo_q,      tmo_d;

    logic [N_CH-1:0]           low_mask;
    logic [CH_W-1:0]           low_idx;
    logic [2*DATA_WIDTH-1:0]   cap_data;
    logic [N_CH-1:0]           remaining;
    logic                      hit;

    // Lowest pending channel: isolate the least significant set bit.
    assign low_mask = pending_q & (~pending_q + N_CH'(1));

    always_comb begin
        low_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) low_idx = CH_W'(i);
        end
    end

    always_comb begin
        cap_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cur_mask_q[i]) begin
                cap_data = {reordered_data_b[i*DATA_WIDTH +: DATA_WIDTH],
                            reordered_data_a[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // In WAIT the request register equals cur_mask_q, so masking with it
    // selects only the channel being served.
    assign hit       = |(valid_read_enable & reordered_valid & cur_mask_q);
    assign remaining = pending_q & ~cur_mask_q;

    // NOTE: every signal assigned here takes its hold value first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        cur_mask_d = cur_mask_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        req_d      = req_q;
        data_d     = data_q;
        ch_d       = ch_q;
        valid_d    = valid_q;
        last_d     = last_q;
        tmo_d      = tmo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pending_d = ch_enable;
                    tmo_d     = '0;
                    state_d   = (ch_enable == '0) ? ST_DONE : ST_SELECT;
                end
            end

            ST_SELECT: begin
                cur_mask_d = low_mask;
                idx_d      = low_idx;
                req_d      = low_mask;
                timer_d    = '0;
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                // A hit in the final timer cycle still wins over the timeout.
                if (hit) begin
                    data_d  = cap_data;
                    ch_d    = idx_q;
                    valid_d = 1'b1;
                    last_d  = (remaining == '0);
                    req_d   = '0;
                    state_d = ST_OUT;
                end else if (timer_q == TIMER_LAST) begin
                    tmo_d     = tmo_q | cur_mask_q;
                    pending_d = remaining;
                    req_d     = '0;
                    state_d   = (remaining == '0) ? ST_DONE : ST_SELECT;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 16'd1;
                end
            end

            ST_OUT: begin
                if (out_ready) begin
                    valid_d   = 1'b0;
                    last_d    = 1'b0;
                    pending_d = remaining;
                    state_d   = (remaining == '0) ? ST_DONE : ST_SELECT;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge data_read_clk) begin
        if (deser_reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            cur_mask_q <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            req_q      <= '0;
            data_q     <= '0;
            ch_q       <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            cur_mask_q <= cur_mask_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            req_q      <= req_d;
            data_q     <= data_d;
            ch_q       <= ch_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            tmo_q      <= tmo_d;
        end
    end

    assign data_read_req = req_q;
    assign out_data      = data_q;
    assign out_ch        = ch_q;
    assign out_valid     = valid_q;
    assign out_last      = last_q;
    assign timeout_err   = tmo_q;
    assign busy          = (state_q == ST_SELECT) || (state_q == ST_WAIT) || (state_q == ST_OUT);
    assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_roic_channel_scheduler.sv
// ============================================================================
// tb_roic_channel_scheduler
//
// Directed bench for roic_channel_scheduler (N_CH=12, DATA_WIDTH=24,
// TIMEOUT_CYC=16). Expected output words are pushed to a scoreboard queue
// when a scan is started; a negedge monitor pops and compares them on each
// stream handshake, and also gathers per-scan statistics (request cycles,
// done pulses, stall behaviour) that the directed steps check afterwards.
// ============================================================================
module tb_roic_channel_scheduler;

    localparam int N_CH = 12;
    localparam int DW   = 24;
    localparam int TMO  = 16;
    localparam int CH_W = 4;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [2*DW-1:0] data;
        logic            last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [N_CH-1:0]      ch_enable;
    logic [N_CH-1:0]      vre;
    logic [N_CH-1:0]      rv;
    logic [N_CH*DW-1:0]   rda;
    logic [N_CH*DW-1:0]   rdb;
    logic [N_CH-1:0]      data_read_req;
    logic [2*DW-1:0]      out_data;
    logic [CH_W-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic [N_CH-1:0]      timeout_err;

    always #5 clk = ~clk;

    roic_channel_scheduler #(
        .N_CH        (N_CH),
        .DATA_WIDTH  (DW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .data_read_clk     (clk),
        .deser_reset       (rst),
        .start             (start),
        .ch_enable         (ch_enable),
        .valid_read_enable (vre),
        .reordered_valid   (rv),
        .reordered_data_a  (rda),
        .reordered_data_b  (rdb),
        .data_read_req     (data_read_req),
        .out_data          (out_data),
        .out_ch            (out_ch),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .busy              (busy),
        .done              (done),
        .timeout_err       (timeout_err)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*DW-1:0] ch_word(input int i);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = DW'(i << 8);
        b = 24'h111011 | DW'(i << 8);
        return {b, a};
    endfunction

    // A live channel is the last word of its scan when no enabled channel
    // (live or dead) sits above it.
    task automatic push_words(input logic [N_CH-1:0] mask, input logic [N_CH-1:0] live);
        exp_t e;
        for (int i = 0; i < N_CH; i++) begin
            if (mask[i] && live[i]) begin
                e.ch   = CH_W'(i);
                e.data = ch_word(i);
                e.last = ((mask >> (i + 1)) == '0);
                sb_q.push_back(e);
            end
        end
    endtask

    // ---------------- monitor ----------------
    int              cyc = 0;
    int              busy_rise_cyc = 0;
    int              done_cyc = 0;
    int              done_cnt = 0;
    int              stall_cnt = 0;
    int              req_cnt[N_CH];
    logic [N_CH-1:0] req_seen = '0;
    logic            busy_seen = 1'b0;
    logic            prev_busy = 1'b0;
    logic            prev_stall = 1'b0;
    logic [2*DW-1:0] prev_data = '0;
    logic [CH_W-1:0] prev_ch = '0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (start === 1'b1 && busy === 1'b0 && done === 1'b0 && rst === 1'b0) begin
            done_cnt  = 0;
            stall_cnt = 0;
            req_seen  = '0;
            busy_seen = 1'b0;
            for (int i = 0; i < N_CH; i++) req_cnt[i] = 0;
        end else begin
            req_seen |= data_read_req;
            for (int i = 0; i < N_CH; i++) if (data_read_req[i] === 1'b1) req_cnt[i]++;
            if (busy === 1'b1 && prev_busy === 1'b0) begin
                busy_rise_cyc = cyc;
                busy_seen     = 1'b1;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", out_data, prev_data);
                check("stall_ch_held", out_ch, prev_ch);
                check("stall_no_req", data_read_req, 0);
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) stall_cnt++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_word", out_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("word_ch", out_ch, e.ch);
                    check("word_data", out_data, e.data);
                    check("word_last", out_last, e.last);
                end
            end
        end
        prev_busy  = (busy === 1'b1);
        prev_stall = (out_valid === 1'b1 && out_ready === 1'b0);
        prev_data  = out_data;
        prev_ch    = out_ch;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [N_CH-1:0] mask);
        tick();
        ch_enable = mask;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
        tick();
        check({tag, "_single"}, done, 0);
    endtask

    task automatic wait_req(input string tag, input int b, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (data_read_req[b] !== 1'b1 && n < budget);
        check(tag, data_read_req[b], 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"}, data_read_req, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_ch"}, out_ch, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_tmo"}, timeout_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ch_enable = '0;
        vre       = '1;
        rv        = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            rda[i*DW +: DW] = ch_word(i)[DW-1:0];
            rdb[i*DW +: DW] = ch_word(i)[2*DW-1:DW];
        end

        // Reset state
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;

        // Full scan: all channels, always valid, ready high
        push_words(12'hFFF, 12'hFFF);
        do_start(12'hFFF);
        wait_done("full_done", 100);
        check("full_done_latency", done_cyc - busy_rise_cyc, 36);
        check("full_sb_empty", sb_q.size(), 0);
        check("full_req_seen", req_seen, 12'hFFF);
        check("full_done_cnt", done_cnt, 1);

        // Sparse mask, plus a start while busy that must be ignored
        push_words(12'h805, 12'hFFF);
        do_start(12'h805);
        tick();
        ch_enable = 12'hFFF;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_done("sparse_done", 100);
        check("sparse_sb_empty", sb_q.size(), 0);
        check("sparse_req_seen", req_seen, 12'h805);
        check("sparse_done_cnt", done_cnt, 1);

        // Backpressure on channel 2's word
        push_words(12'h00F, 12'hFFF);
        do_start(12'h00F);
        wait_req("bp_req2", 2, 50);
        out_ready = 1'b0;
        repeat (6) tick();
        check("bp_valid_held", out_valid, 1);
        check("bp_ch_held", out_ch, 2);
        out_ready = 1'b1;
        tick();
        check("bp_h1_no_req", data_read_req, 0);
        check("bp_h1_busy", busy, 1);
        tick();
        check("bp_h2_req3", data_read_req, 12'h008);
        wait_done("bp_done", 100);
        check("bp_stall_cnt", stall_cnt, 5);
        check("bp_sb_empty", sb_q.size(), 0);

        // Timeout on channel 5
        rv = 12'hFDF;
        push_words(12'hFFF, 12'hFDF);
        do_start(12'hFFF);
        wait_done("tmo_done", 200);
        check("tmo_req5_cycles", req_cnt[5], TMO);
        check("tmo_err", timeout_err, 12'h020);
        check("tmo_sb_empty", sb_q.size(), 0);

        // Hit exactly in the timeout cycle of channel 3
        rv = '0;
        push_words(12'h008, 12'hFFF);
        do_start(12'h008);
        check("hit_last_tmo_cleared", timeout_err, 0);
        wait_req("hit_last_req3", 3, 10);
        repeat (TMO - 1) tick();
        rv = 12'h008;
        tick();
        rv = '0;
        check("hit_last_valid", out_valid, 1);
        check("hit_last_req_off", data_read_req, 0);
        wait_done("hit_last_done", 50);
        check("hit_last_tmo", timeout_err, 0);
        check("hit_last_req_cycles", req_cnt[3], TMO);
        check("hit_last_sb_empty", sb_q.size(), 0);

        // Empty mask
        rv = '1;
        do_start(12'h000);
        check("empty_done", done, 1);
        check("empty_busy", busy, 0);
        tick();
        check("empty_done_single", done, 0);
        check("empty_busy_seen", busy_seen, 0);
        check("empty_done_cnt", done_cnt, 1);

        // Reset while waiting on channel 0 (read enable held low)
        vre = '0;
        do_start(12'h00F);
        wait_req("rst_req0", 0, 10);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_idle_outputs("midscan_reset");
        rst = 1'b0;
        vre = '1;
        repeat (5) tick();
        check("midscan_no_done", done_cnt, 0);
        check("midscan_idle_busy", busy, 0);
        check("midscan_idle_req", data_read_req, 0);
        check("midscan_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
